// File: rtl/regs_file_if.sv
// Bundle of signals between decode/write-back and the register file.
// Request semantics: a read request (rd_req_in) is accepted in the cycle it is
// high while ready_out=1 and hazard_out=0. An accepted request returns data
// with a single-cycle rd_valid_out pulse on the next cycle. A request that
// sees hazard_out=1 is not accepted and must be held or retried by decode.
interface regs_file_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] regs_data_in;
  logic [7:0]       regs_wr_id_in;
  logic             regs_write_in;
  logic             rd_req_in;
  logic [7:0]       rs1_id_in;
  logic [7:0]       rs2_id_in;
  logic             issue_in;
  logic [7:0]       issue_rd_in;
  logic [WIDTH-1:0] rs1_data_out;
  logic [WIDTH-1:0] rs2_data_out;
  logic             rd_valid_out;
  logic             hazard_out;
  logic             ready_out;
  logic             fsm_state;

  modport master (
    output regs_data_in, regs_wr_id_in, regs_write_in, rd_req_in,
           rs1_id_in, rs2_id_in, issue_in, issue_rd_in,
    input  rs1_data_out, rs2_data_out, rd_valid_out, hazard_out,
           ready_out, fsm_state
  );

  modport slave (
    input  regs_data_in, regs_wr_id_in, regs_write_in, rd_req_in,
           rs1_id_in, rs2_id_in, issue_in, issue_rd_in,
    output rs1_data_out, rs2_data_out, rd_valid_out, hazard_out,
           ready_out, fsm_state
  );
endinterface

// File: rtl/regs_file.sv
// Architectural register file with zeroing sweep after reset, write-to-read
// bypass and a per-register busy scoreboard that flags read hazards.
module regs_file #(
  parameter int REGS  = 32,
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  regs_file_if.slave bus
);
  localparam int IW = (REGS > 1) ? $clog2(REGS) : 1;
  localparam int CW = $clog2(REGS + 1);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    sweep;
  logic [WIDTH-1:0] regs [REGS];
  logic [REGS-1:0]  busy;
  logic [REGS-1:0]  busy_eff;
  logic [REGS-1:0]  busy_next;
  logic [WIDTH-1:0] rs1_q, rs2_q;
  logic [WIDTH-1:0] rd1, rd2;
  logic             valid_q, ready_q;
  logic             wr_ok, hazard, issue_ok, accept;
  logic [IW-1:0]    wr_idx, issue_idx;

  function automatic logic in_range(input logic [7:0] id);
    return (id != 8'd0) && ({24'd0, id} < REGS);
  endfunction

  function automatic logic pending(input logic [REGS-1:0] vec, input logic [7:0] id);
    return in_range(id) && vec[id[IW-1:0]];
  endfunction

  function automatic logic [WIDTH-1:0] read_val(input logic [7:0] id);
    logic [WIDTH-1:0] v;
    v = '0;
    if (in_range(id)) begin
      if (wr_ok && (id == bus.regs_wr_id_in)) v = bus.regs_data_in;
      else                                    v = regs[id[IW-1:0]];
    end
    return v;
  endfunction

  always_comb begin
    wr_idx    = bus.regs_wr_id_in[IW-1:0];
    issue_idx = bus.issue_rd_in[IW-1:0];
    wr_ok     = (state == RUN) && bus.regs_write_in && in_range(bus.regs_wr_id_in);
    // A register being written this cycle is no longer pending: the bypass covers it.
    busy_eff  = busy;
    if (wr_ok) busy_eff[wr_idx] = 1'b0;
    hazard    = (state == RUN) && bus.rd_req_in &&
                (pending(busy_eff, bus.rs1_id_in) || pending(busy_eff, bus.rs2_id_in) ||
                 (bus.issue_in && pending(busy_eff, bus.issue_rd_in)));
    issue_ok  = (state == RUN) && bus.issue_in && !hazard && in_range(bus.issue_rd_in);
    busy_next = busy_eff;
    if (issue_ok) busy_next[issue_idx] = 1'b1;
    accept    = (state == RUN) && bus.rd_req_in && !hazard;
    rd1       = read_val(bus.rs1_id_in);
    rd2       = read_val(bus.rs2_id_in);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= INIT;
      sweep   <= '0;
      busy    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          valid_q <= 1'b0;
          if (sweep == CW'(REGS)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            sweep <= sweep + CW'(1);
          end
        end
        RUN: begin
          busy    <= busy_next;
          valid_q <= accept;
          if (accept) begin
            rs1_q <= rd1;
            rs2_q <= rd2;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Storage carries no reset; the INIT sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == INIT && sweep != CW'(REGS)) regs[sweep[IW-1:0]] <= '0;
    else if (wr_ok)                          regs[wr_idx]        <= bus.regs_data_in;
  end

  assign bus.rs1_data_out = rs1_q;
  assign bus.rs2_data_out = rs2_q;
  assign bus.rd_valid_out = valid_q;
  assign bus.hazard_out   = hazard;
  assign bus.ready_out    = ready_q;
  assign bus.fsm_state    = state;
endmodule

// File: tb/tb_regs_file.sv
// Directed and randomized checks of regs_file against an array-based model
// of registers, busy bits and read results.
module tb_regs_file;
  localparam int REGS  = 32;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regs_file_if #(.WIDTH(WIDTH)) bus();
  regs_file #(.REGS(REGS), .WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] m_regs [REGS];
  bit               m_busy [REGS];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_rs1, exp_rs2;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit valid_id(input logic [7:0] id);
    return (id != 8'd0) && (int'(id) < REGS);
  endfunction

  function automatic bit m_pending(input logic [7:0] id, input bit wr_ok, input logic [7:0] wid);
    if (!valid_id(id)) return 1'b0;
    if (wr_ok && wid == id) return 1'b0;
    return m_busy[int'(id)];
  endfunction

  function automatic logic [WIDTH-1:0] m_value(input logic [7:0] id, input bit wr_ok,
                                               input logic [7:0] wid, input logic [WIDTH-1:0] wd);
    if (!valid_id(id)) return '0;
    if (wr_ok && wid == id) return wd;
    return m_regs[int'(id)];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < REGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    exp_q.delete();
    exp_rs1 = '0;
    exp_rs2 = '0;
  endtask

  task automatic idle();
    bus.regs_write_in = 1'b0; bus.regs_wr_id_in = '0; bus.regs_data_in = '0;
    bus.rd_req_in = 1'b0; bus.rs1_id_in = '0; bus.rs2_id_in = '0;
    bus.issue_in = 1'b0; bus.issue_rd_in = '0;
  endtask

  // One RUN cycle, entered and left on a falling edge.
  task automatic step(input bit wr, input logic [7:0] wid, input logic [WIDTH-1:0] wd,
                      input bit rq, input logic [7:0] r1, input logic [7:0] r2,
                      input bit iss, input logic [7:0] ird);
    bit wr_ok, hz, acc;
    logic [WIDTH-1:0] v1, v2;
    bus.regs_write_in = wr; bus.regs_wr_id_in = wid; bus.regs_data_in = wd;
    bus.rd_req_in = rq; bus.rs1_id_in = r1; bus.rs2_id_in = r2;
    bus.issue_in = iss; bus.issue_rd_in = ird;
    wr_ok = wr && valid_id(wid);
    hz  = rq && (m_pending(r1, wr_ok, wid) || m_pending(r2, wr_ok, wid) ||
                 (iss && m_pending(ird, wr_ok, wid)));
    acc = rq && !hz;
    v1  = m_value(r1, wr_ok, wid, wd);
    v2  = m_value(r2, wr_ok, wid, wd);
    #1;
    check("hazard", bus.hazard_out, hz);
    if (acc) begin
      exp_q.push_back(v1);
      exp_q.push_back(v2);
    end
    if (wr_ok) begin
      m_regs[int'(wid)] = wd;
      m_busy[int'(wid)] = 1'b0;
    end
    if (iss && !hz && valid_id(ird)) m_busy[int'(ird)] = 1'b1;
    @(posedge clk);
    #1;
    check("rd_valid", bus.rd_valid_out, acc);
    check("ready", bus.ready_out, 1);
    if (acc && exp_q.size() >= 2) begin
      exp_rs1 = exp_q.pop_front();
      exp_rs2 = exp_q.pop_front();
    end
    check("rs1_data", bus.rs1_data_out, exp_rs1);
    check("rs2_data", bus.rs2_data_out, exp_rs2);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_valid"}, bus.rd_valid_out, 0);
    check({tag, "_hazard"}, bus.hazard_out, 0);
    check({tag, "_ready"}, bus.ready_out, 0);
    check({tag, "_rs1"}, bus.rs1_data_out, 0);
    check({tag, "_rs2"}, bus.rs2_data_out, 0);
  endtask

  // Release reset on a falling edge and walk the whole sweep with random, ignored inputs.
  task automatic init_sweep();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("ready_after_release", bus.ready_out, 0);
    for (int n = 1; n <= REGS + 1; n++) begin
      bus.regs_write_in = 1'($urandom_range(0, 1));
      bus.regs_wr_id_in = 8'($urandom_range(0, 40));
      bus.regs_data_in  = $urandom;
      bus.rd_req_in     = 1'($urandom_range(0, 1));
      bus.rs1_id_in     = 8'($urandom_range(0, 40));
      bus.rs2_id_in     = 8'($urandom_range(0, 40));
      bus.issue_in      = 1'($urandom_range(0, 1));
      bus.issue_rd_in   = 8'($urandom_range(0, 40));
      #1;
      check("init_hazard", bus.hazard_out, 0);
      @(posedge clk);
      #1;
      check("init_rd_valid", bus.rd_valid_out, 0);
      check("init_ready", bus.ready_out, (n == REGS + 1) ? 1 : 0);
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    #3 reset = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    init_sweep();

    // Every register reads zero after the sweep.
    for (int i = 0; i < REGS; i++)
      step(0, 0, 0, 1, 8'(i), 8'(REGS - 1 - i), 0, 0);

    // Write then read, back-to-back.
    step(1, 8'd5, 32'h1234, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8'd5, 8'd0, 0, 0);
    check("x5_rs1", bus.rs1_data_out, 32'h1234);
    check("x5_rs2", bus.rs2_data_out, 32'h0);

    // Same-cycle bypass.
    step(1, 8'd7, 32'hDEAD, 1, 8'd7, 8'd5, 0, 0);
    check("x7_bypass", bus.rs1_data_out, 32'hDEAD);

    // Dropped writes to x0 and beyond the file.
    step(1, 8'd0, 32'hFF, 0, 0, 0, 0, 0);
    step(1, 8'd40, 32'hAB, 1, 8'd0, 8'd40, 0, 0);
    step(0, 0, 0, 1, 8'd0, 8'd40, 0, 0);
    check("x0_read", bus.rs1_data_out, 32'h0);

    // Hazard on a reserved register, released by write-back while held.
    step(0, 0, 0, 0, 0, 0, 1, 8'd3);
    step(0, 0, 0, 1, 8'd3, 8'd0, 0, 0);
    step(0, 0, 0, 1, 8'd3, 8'd0, 0, 0);
    step(1, 8'd3, 32'h55, 1, 8'd3, 8'd0, 0, 0);
    check("x3_release", bus.rs1_data_out, 32'h55);

    // Issue and write of the same register in one cycle: reservation survives.
    step(1, 8'd9, 32'h99, 0, 0, 0, 1, 8'd9);
    step(0, 0, 0, 1, 8'd0, 8'd9, 0, 0);
    step(1, 8'd9, 32'h77, 1, 8'd0, 8'd9, 0, 0);
    check("x9_after_clear", bus.rs2_data_out, 32'h77);

    // Issue of a busy register under a hazard is ignored.
    step(0, 0, 0, 0, 0, 0, 1, 8'd11);
    step(0, 0, 0, 1, 8'd11, 8'd0, 1, 8'd12);
    step(0, 0, 0, 1, 8'd12, 8'd0, 0, 0);
    step(1, 8'd11, 32'h1111, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)), $urandom,
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)),
           ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 40)));

    // Reset during a hazarded read while x4 is reserved.
    for (int i = 1; i < REGS; i++) step(1, 8'(i), 32'(i * 3 + 1), 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8'd7, 8'd8, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 8'd4);
    bus.rd_req_in = 1'b1; bus.rs1_id_in = 8'd4; bus.rs2_id_in = 8'd0;
    #1 check("pre_reset_hazard", bus.hazard_out, 1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    init_sweep();
    step(0, 0, 0, 1, 8'd4, 8'd7, 0, 0);
    check("x4_after_reset", bus.rs1_data_out, 32'h0);
    step(1, 8'd0, 32'hFF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8'd0, 8'd4, 0, 0);
    check("x0_after_reset", bus.rs1_data_out, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
